boss_enemy_controller: RTL and testbench
========================================

# boss_enemy_controller

Parametrised enemy controller for the shooter game datapath, running in the 25 MHz pixel-clock domain between the player-bullet manager and the sprite renderer. It spawns one enemy sprite when enabled, moves it horizontally with a wall-bounce descent, and checks it against N player bullets every cycle. It applies multi-hit damage with an invulnerability window and sequences a death phase before reporting the kill. Compared with the fixed 8-bullet spider controller, it adds width/depth parameters, reset, HP output, hit-flash, a one-cycle kill pulse, and no auto-respawn.

## Interface
Parameters:
- N_BULLETS, 8, bullet slots checked per cycle
- COORD_W, 10, coordinate width per bullet/enemy axis
- HP_MAX, 10, HP loaded at spawn (≥1); HP_W = $clog2(HP_MAX+1)
- SPR_W / SPR_H, 32 / 32, enemy sprite size in pixels
- BULLET_SZ, 8, bullet extent added to bullet x/y for overlap
- SCREEN_W, 640, playfield width; SPAWN_X 320, SPAWN_Y 0
- MARGIN, 10, horizontal wall margin
- MOVE_DIV, 500000, clocks per movement tick; STEP, 2, pixels per tick
- DESCEND, 8, y increment per wall bounce; Y_MAX, 400, y clamp
- INVULN_CYC, 2500000, invulnerability length after damage
- DEATH_CYC, 12500000, length of DYING phase

Ports:
- clk25  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  level; high requests an enemy, low returns to IDLE
- bullet_x_flat  in  N_BULLETS*COORD_W  bullet i x at [i*COORD_W +: COORD_W]
- bullet_y_flat  in  N_BULLETS*COORD_W  bullet i y, same packing
- bullet_active_flat  in  N_BULLETS  bullet i valid
- enemy_x / enemy_y  out  COORD_W  sprite top-left
- enemy_alive  out  1  high only in ALIVE
- enemy_hp  out  HP_W  current HP
- hit_flash  out  1  high while invulnerability timer is nonzero
- dying  out  1  high in DYING (renderer plays explosion)
- killed_pulse  out  1  one-cycle pulse on ALIVE→DYING
- bullet_hit  out  N_BULLETS  one-cycle per-slot consume pulses

## Operation
- States: IDLE, SPAWN, ALIVE, DYING, DEAD.
- Reset (rst_n=0 at an edge): state IDLE, x=SPAWN_X, y=SPAWN_Y, dir=right, hp=0, counters 0, all outputs 0. Reset overrides every other input.
- IDLE: holds reset values. enable=1 → SPAWN.
- SPAWN (1 cycle): load hp=HP_MAX, x/y=spawn, dir=right, counters 0 → ALIVE.
- enable=0 in any non-IDLE state → IDLE next cycle with reset values. This is a mid-life abort: no killed_pulse.
- ALIVE movement: move counter runs 0..MOVE_DIV-1 and ticks at MOVE_DIV-1.
  - On a tick moving right: if x+STEP ≥ SCREEN_W-SPR_W-MARGIN, then x = SCREEN_W-SPR_W-MARGIN, dir=left, y=min(y+DESCEND, Y_MAX); else x += STEP.
  - On a tick moving left: if x ≤ MARGIN+STEP, then x = MARGIN, dir=right, same descent; else x -= STEP.
- ALIVE collision for bullet i: active_i && bx+BULLET_SZ ≥ ex && bx ≤ ex+SPR_W-1 && by+BULLET_SZ ≥ ey && by ≤ ey+SPR_H-1.
  - Compute in COORD_W+1 bits; no wrap.
  - Use the current registered positions.
- Every overlapping bullet gets bullet_hit[i]=1, including during invulnerability.
- Damage when the invulnerability timer is 0: hp -= popcount(overlaps), saturating at 0. The timer loads INVULN_CYC on any nonzero damage.
- While the timer is nonzero: no damage, and the timer decrements each cycle.
- hp reaching 0 → DYING. killed_pulse is 1 on the transition cycle, the DEATH_CYC counter starts, and position freezes.
- DYING: counts to DEATH_CYC-1 → DEAD. No collisions, bullet_hit=0.
- DEAD: enemy_alive=0, hp=0. Stays there until enable=0 (→IDLE); re-spawn requires enable to go low then high.

## Timing
- All outputs are registered.
- bullet_hit, hp, and the state change reflect bullets sampled at edge k, visible after edge k (latency 1).
- A bullet held active for M cycles while overlapping gets M consecutive hit pulses; the bullet manager must clear active within 1 cycle.
- Movement tick and collision in the same cycle: collision uses the pre-move position.
- Tick and death in the same cycle: DYING wins, and position keeps its pre-tick value.
- SPAWN→ALIVE takes 2 cycles from enable rising: IDLE sees enable at edge 0, SPAWN after edge 0, ALIVE after edge 1.
- killed_pulse is exactly 1 cycle wide. hit_flash falls the cycle the timer reaches 0.

## Test plan
Use a bench parametrisation of MOVE_DIV=4, INVULN_CYC=3, DEATH_CYC=5, HP_MAX=3, N_BULLETS=8.
- Reset/spawn: rst_n=0 for 2 cycles, then enable=1 → outputs 0 during reset; after 2 edges, alive=1, hp=3, x=320, y=0.
- Movement/bounce: hold ALIVE with no bullets → x increments by 2 every 4 cycles. At x=598, next tick gives x=598, dir=left, y=8. Preload x=12 moving left → x=10, dir=right, y+=8.
- Multi-hit: 2 bullets overlapping at (324,4) in one cycle → bullet_hit=0b11, hp 3→1, hit_flash=1 for 3 cycles. A bullet in cycle 2 of the flash → hit pulse, hp stays 1.
- Kill: a 3-bullet simultaneous overlap at hp=3 → hp=0, killed_pulse for 1 cycle, dying=1 for 5 cycles, then DEAD. enable held high → no respawn. enable low then high → fresh spawn.
- Boundaries: bullet x=312 (bx+8=ex) hits; bullet x=352 (ex+32) misses. Bullet with active=0 overlapping → no hit.
- Abort: enable=0 mid-ALIVE at hp=2 → IDLE next cycle, no killed_pulse. rst_n=0 during DYING → IDLE with all outputs 0.

Source files
------------

// File: rtl/boss_enemy_controller.sv
`default_nettype none
// ============================================================================
// Module   : boss_enemy_controller
// Purpose  : Single boss enemy: spawn, bounce-descend motion, N-bullet
//            multi-hit damage with invulnerability, timed death phase.
// Revision : 1.0 - initial release
// ============================================================================
module boss_enemy_controller #(
    parameter int N_BULLETS  = 8,
    parameter int COORD_W    = 10,
    parameter int HP_MAX     = 10,
    parameter int HP_W       = $clog2(HP_MAX + 1),
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int BULLET_SZ  = 8,
    parameter int SCREEN_W   = 640,
    parameter int SPAWN_X    = 320,
    parameter int SPAWN_Y    = 0,
    parameter int MARGIN     = 10,
    parameter int MOVE_DIV   = 500000,
    parameter int STEP       = 2,
    parameter int DESCEND    = 8,
    parameter int Y_MAX      = 400,
    parameter int INVULN_CYC = 2500000,
    parameter int DEATH_CYC  = 12500000
) (
    input  logic                           clk25,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [N_BULLETS*COORD_W-1:0]   bullet_x_flat,
    input  logic [N_BULLETS*COORD_W-1:0]   bullet_y_flat,
    input  logic [N_BULLETS-1:0]           bullet_active_flat,
    output logic [COORD_W-1:0]             enemy_x,
    output logic [COORD_W-1:0]             enemy_y,
    output logic                           enemy_alive,
    output logic [HP_W-1:0]                enemy_hp,
    output logic                           hit_flash,
    output logic                           dying,
    output logic                           killed_pulse,
    output logic [N_BULLETS-1:0]           bullet_hit
);

    localparam int c_mv_w  = $clog2(MOVE_DIV + 1);
    localparam int c_tm_w  = $clog2(INVULN_CYC + 1);
    localparam int c_dc_w  = $clog2(DEATH_CYC + 1);
    localparam int c_pc_w  = $clog2(N_BULLETS + 1);
    localparam int c_ext_w = COORD_W + 1;
    localparam int c_hd_w  = HP_W + c_pc_w;

    localparam logic [c_ext_w-1:0] c_right_x  = c_ext_w'(SCREEN_W - SPR_W - MARGIN);
    localparam logic [c_ext_w-1:0] c_left_x   = c_ext_w'(MARGIN);
    localparam logic [c_ext_w-1:0] c_left_thr = c_ext_w'(MARGIN + STEP);
    localparam logic [c_ext_w-1:0] c_step     = c_ext_w'(STEP);
    localparam logic [c_ext_w-1:0] c_desc     = c_ext_w'(DESCEND);
    localparam logic [c_ext_w-1:0] c_ymax     = c_ext_w'(Y_MAX);
    localparam logic [c_ext_w-1:0] c_bsz      = c_ext_w'(BULLET_SZ);
    localparam logic [c_ext_w-1:0] c_sprw_m1  = c_ext_w'(SPR_W - 1);
    localparam logic [c_ext_w-1:0] c_sprh_m1  = c_ext_w'(SPR_H - 1);
    localparam logic [COORD_W-1:0] c_step_n   = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] c_spawn_x  = COORD_W'(SPAWN_X);
    localparam logic [COORD_W-1:0] c_spawn_y  = COORD_W'(SPAWN_Y);
    localparam logic [c_mv_w-1:0]  c_move_last  = c_mv_w'(MOVE_DIV - 1);
    localparam logic [c_tm_w-1:0]  c_invuln     = c_tm_w'(INVULN_CYC);
    localparam logic [c_tm_w-1:0]  c_tm_one     = c_tm_w'(1);
    localparam logic [c_dc_w-1:0]  c_death_last = c_dc_w'(DEATH_CYC - 1);
    localparam logic [HP_W-1:0]    c_hp_max     = HP_W'(HP_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_ALIVE = 3'd2,
        ST_DYING = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_dir_left;
    logic [c_mv_w-1:0]   r_move_cnt;
    logic [c_tm_w-1:0]   r_timer;
    logic [c_dc_w-1:0]   r_death_cnt;

    logic [c_ext_w-1:0]  w_ex, w_ey, w_x_inc, w_x_ext, w_y_sum;
    logic [COORD_W-1:0]  w_y_next;
    logic [N_BULLETS-1:0] w_overlap;
    logic [c_pc_w-1:0]   w_dmg;
    logic [c_hd_w-1:0]   w_hp_ext, w_dmg_ext;
    logic [HP_W-1:0]     w_hp_after;
    logic                w_take_dmg, w_kill, w_tick;

    assign w_ex = {1'b0, enemy_x};
    assign w_ey = {1'b0, enemy_y};

    // Widened by one bit so sprite/bullet extents near the top of the range never wrap
    for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_bullet
        logic [c_ext_w-1:0] w_bx, w_by;
        assign w_bx = {1'b0, bullet_x_flat[gi*COORD_W +: COORD_W]};
        assign w_by = {1'b0, bullet_y_flat[gi*COORD_W +: COORD_W]};
        assign w_overlap[gi] = bullet_active_flat[gi]
                            && (w_bx + c_bsz >= w_ex) && (w_bx <= w_ex + c_sprw_m1)
                            && (w_by + c_bsz >= w_ey) && (w_by <= w_ey + c_sprh_m1);
    end

    always_comb begin
        w_dmg = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            w_dmg = w_dmg + c_pc_w'(w_overlap[i]);
        end
    end

    assign w_hp_ext   = c_hd_w'(enemy_hp);
    assign w_dmg_ext  = c_hd_w'(w_dmg);
    assign w_hp_after = (w_hp_ext > w_dmg_ext) ? HP_W'(w_hp_ext - w_dmg_ext) : '0;
    assign w_take_dmg = (r_timer == '0) && (w_dmg != '0);
    assign w_kill     = w_take_dmg && (w_hp_after == '0);
    assign w_tick     = (r_move_cnt == c_move_last);

    assign w_x_ext  = {1'b0, enemy_x};
    assign w_x_inc  = w_x_ext + c_step;
    assign w_y_sum  = w_ey + c_desc;
    assign w_y_next = (w_y_sum > c_ymax) ? c_ymax[COORD_W-1:0] : w_y_sum[COORD_W-1:0];

    always_ff @(posedge clk25) begin
        if (!rst_n || !enable) begin
            r_state      <= ST_IDLE;
            enemy_x      <= c_spawn_x;
            enemy_y      <= c_spawn_y;
            r_dir_left   <= 1'b0;
            enemy_hp     <= '0;
            r_move_cnt   <= '0;
            r_timer      <= '0;
            r_death_cnt  <= '0;
            enemy_alive  <= 1'b0;
            hit_flash    <= 1'b0;
            dying        <= 1'b0;
            killed_pulse <= 1'b0;
            bullet_hit   <= '0;
        end else begin
            killed_pulse <= 1'b0;
            bullet_hit   <= '0;
            // Invulnerability keeps draining through the death phase
            if (r_timer != '0) begin
                r_timer   <= r_timer - 1'b1;
                hit_flash <= (r_timer != c_tm_one);
            end
            case (r_state)
                ST_IDLE: r_state <= ST_SPAWN;
                ST_SPAWN: begin
                    enemy_hp    <= c_hp_max;
                    enemy_x     <= c_spawn_x;
                    enemy_y     <= c_spawn_y;
                    r_dir_left  <= 1'b0;
                    r_move_cnt  <= '0;
                    r_death_cnt <= '0;
                    enemy_alive <= 1'b1;
                    r_state     <= ST_ALIVE;
                end
                ST_ALIVE: begin
                    bullet_hit <= w_overlap;
                    if (w_take_dmg) begin
                        r_timer   <= c_invuln;
                        hit_flash <= 1'b1;
                        enemy_hp  <= w_hp_after;
                    end
                    r_move_cnt <= w_tick ? '0 : r_move_cnt + 1'b1;
                    if (w_kill) begin
                        r_state      <= ST_DYING;
                        enemy_alive  <= 1'b0;
                        dying        <= 1'b1;
                        killed_pulse <= 1'b1;
                        r_death_cnt  <= '0;
                    end else if (w_tick) begin
                        if (!r_dir_left) begin
                            if (w_x_inc >= c_right_x) begin
                                enemy_x    <= c_right_x[COORD_W-1:0];
                                r_dir_left <= 1'b1;
                                enemy_y    <= w_y_next;
                            end else begin
                                enemy_x <= w_x_inc[COORD_W-1:0];
                            end
                        end else begin
                            if (w_x_ext <= c_left_thr) begin
                                enemy_x    <= c_left_x[COORD_W-1:0];
                                r_dir_left <= 1'b0;
                                enemy_y    <= w_y_next;
                            end else begin
                                enemy_x <= enemy_x - c_step_n;
                            end
                        end
                    end
                end
                ST_DYING: begin
                    if (r_death_cnt == c_death_last) begin
                        r_state <= ST_DEAD;
                        dying   <= 1'b0;
                    end else begin
                        r_death_cnt <= r_death_cnt + 1'b1;
                    end
                end
                ST_DEAD: begin
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boss_enemy_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_boss_enemy_controller
// Purpose  : Scoreboard bench; a behavioural model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boss_enemy_controller;

    localparam int N    = 8;
    localparam int CW   = 10;
    localparam int HPM  = 3;
    localparam int HP_W = $clog2(HPM + 1);

    localparam int S_IDLE = 0, S_SPAWN = 1, S_ALIVE = 2, S_DYING = 3, S_DEAD = 4;

    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic                rst_n, enable;
    logic [N*CW-1:0]     bullet_x_flat, bullet_y_flat;
    logic [N-1:0]        bullet_active_flat;
    logic [CW-1:0]       enemy_x, enemy_y;
    logic                enemy_alive, hit_flash, dying, killed_pulse;
    logic [HP_W-1:0]     enemy_hp;
    logic [N-1:0]        bullet_hit;

    boss_enemy_controller #(
        .N_BULLETS(N), .COORD_W(CW), .HP_MAX(HPM),
        .MOVE_DIV(4), .INVULN_CYC(3), .DEATH_CYC(5)
    ) u_dut (
        .clk25(clk25), .rst_n(rst_n), .enable(enable),
        .bullet_x_flat(bullet_x_flat), .bullet_y_flat(bullet_y_flat),
        .bullet_active_flat(bullet_active_flat),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
        .enemy_hp(enemy_hp), .hit_flash(hit_flash), .dying(dying),
        .killed_pulse(killed_pulse), .bullet_hit(bullet_hit)
    );

    typedef struct {
        int     x, y, hp;
        bit     alive, dying, killed, flash;
        bit [N-1:0] hits;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_st = S_IDLE, m_x = 320, m_y = 0, m_dir = 0, m_hp = 0;
    int   m_mcnt = 0, m_tmr = 0, m_dcnt = 0, m_bounces = 0;
    bit   m_killed = 0;
    bit [N-1:0] m_hits = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp_v);
        end
    endtask

    task automatic set_bullet(input int i, input int bx, input int by, input bit act);
        bullet_x_flat[i*CW +: CW] = CW'(bx);
        bullet_y_flat[i*CW +: CW] = CW'(by);
        bullet_active_flat[i]     = act;
    endtask

    task automatic clear_bullets();
        bullet_x_flat      = '0;
        bullet_y_flat      = '0;
        bullet_active_flat = '0;
    endtask

    task automatic model_update();
        int n;
        bit tick;
        m_hits   = '0;
        m_killed = 0;
        if (!rst_n || !enable) begin
            m_st = S_IDLE; m_x = 320; m_y = 0; m_dir = 0; m_hp = 0;
            m_mcnt = 0; m_tmr = 0; m_dcnt = 0;
        end else begin
            case (m_st)
                S_IDLE: m_st = S_SPAWN;
                S_SPAWN: begin
                    m_hp = HPM; m_x = 320; m_y = 0; m_dir = 0;
                    m_mcnt = 0; m_tmr = 0; m_dcnt = 0; m_bounces = 0;
                    m_st = S_ALIVE;
                end
                S_ALIVE: begin
                    n = 0;
                    for (int i = 0; i < N; i++) begin
                        int bx, by;
                        bx = int'(bullet_x_flat[i*CW +: CW]);
                        by = int'(bullet_y_flat[i*CW +: CW]);
                        if (bullet_active_flat[i] && bx + 8 >= m_x && bx <= m_x + 31
                            && by + 8 >= m_y && by <= m_y + 31) begin
                            m_hits[i] = 1'b1;
                            n++;
                        end
                    end
                    if (m_tmr > 0) m_tmr--;
                    else if (n > 0) begin
                        m_hp  = (m_hp > n) ? m_hp - n : 0;
                        m_tmr = 3;
                    end
                    tick   = (m_mcnt == 3);
                    m_mcnt = tick ? 0 : m_mcnt + 1;
                    if (m_hp == 0) begin
                        m_st = S_DYING; m_killed = 1; m_dcnt = 0;
                    end else if (tick) begin
                        if (m_dir == 0) begin
                            if (m_x + 2 >= 598) begin
                                m_x = 598; m_dir = 1; m_y = (m_y + 8 > 400) ? 400 : m_y + 8; m_bounces++;
                            end else m_x += 2;
                        end else begin
                            if (m_x <= 12) begin
                                m_x = 10; m_dir = 0; m_y = (m_y + 8 > 400) ? 400 : m_y + 8; m_bounces++;
                            end else m_x -= 2;
                        end
                    end
                end
                S_DYING: begin
                    if (m_tmr > 0) m_tmr--;
                    if (m_dcnt == 4) m_st = S_DEAD;
                    else m_dcnt++;
                end
                default: if (m_tmr > 0) m_tmr--;
            endcase
        end
    endtask

    // Predict from the inputs about to be sampled, then compare after the edge
    task automatic step();
        exp_t e, got;
        model_update();
        e.x = m_x; e.y = m_y; e.hp = m_hp;
        e.alive = (m_st == S_ALIVE); e.dying = (m_st == S_DYING);
        e.killed = m_killed; e.flash = (m_tmr != 0); e.hits = m_hits;
        sb_q.push_back(e);
        @(posedge clk25);
        #1;
        got = sb_q.pop_front();
        check_val("enemy_x",      enemy_x,      got.x);
        check_val("enemy_y",      enemy_y,      got.y);
        check_val("enemy_hp",     enemy_hp,     got.hp);
        check_val("enemy_alive",  enemy_alive,  got.alive);
        check_val("dying",        dying,        got.dying);
        check_val("killed_pulse", killed_pulse, got.killed);
        check_val("hit_flash",    hit_flash,    got.flash);
        check_val("bullet_hit",   bullet_hit,   got.hits);
    endtask

    task automatic three_hit();
        set_bullet(0, m_x + 4,  m_y + 4, 1'b1);
        set_bullet(1, m_x + 12, m_y + 4, 1'b1);
        set_bullet(2, m_x + 20, m_y + 10, 1'b1);
        step();
        clear_bullets();
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        clear_bullets();
        repeat (2) step();

        // Spawn and free movement
        rst_n = 1'b1;
        enable = 1'b1;
        step(); step();
        check_val("spawn_hp", enemy_hp, 3);
        check_val("spawn_x", enemy_x, 320);
        repeat (12) step();

        // Inactive overlapping bullet, right-edge miss, left-edge hit
        set_bullet(0, m_x + 4, m_y + 4, 1'b0); step(); clear_bullets();
        set_bullet(0, m_x + 32, m_y + 4, 1'b1); step(); clear_bullets();
        set_bullet(0, m_x - 8, m_y, 1'b1); step(); clear_bullets();
        repeat (4) step();

        // Mid-life abort, then respawn
        enable = 1'b0; step();
        enable = 1'b1; step(); step();

        // Double hit, then a hit inside the invulnerability window
        set_bullet(0, m_x + 4,  m_y + 4, 1'b1);
        set_bullet(1, m_x + 10, m_y + 4, 1'b1);
        step(); clear_bullets();
        step();
        set_bullet(2, m_x + 4, m_y + 4, 1'b1); step(); clear_bullets();
        repeat (5) step();

        // Fresh spawn, kill, death phase, no auto-respawn
        enable = 1'b0; step();
        enable = 1'b1; step(); step();
        three_hit();
        repeat (10) step();
        enable = 1'b0; step();
        enable = 1'b1; repeat (3) step();

        // Reset during the death phase
        three_hit();
        step(); step();
        rst_n = 1'b0; step(); step();
        rst_n = 1'b1; step(); step();

        // Full traverse: right wall bounce then left wall bounce
        for (int c = 0; c < 4000; c++) begin
            step();
            if (m_bounces >= 2) break;
        end
        check_val("left_bounce_x", enemy_x, 10);
        check_val("left_bounce_y", enemy_y, 16);
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
